// File: rtl/conv_mac_seq_if.sv
// Handshake and operand bus between the pixel window, the convolution MAC engine
// and the output pixel writer.
interface conv_mac_seq_if #(
  parameter int unsigned BITS        = 9,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned SHIFT_BITS  = 4
);
  localparam int unsigned NTAPS = KERNEL_SIZE * KERNEL_SIZE;

  logic                    in_valid;
  logic                    in_ready;
  logic [NTAPS*BITS-1:0]   shift_in;
  logic [NTAPS*BITS-1:0]   kernel_in;
  logic [SHIFT_BITS-1:0]   shamt;
  logic                    relu_en;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [BITS-1:0]  pixel_out;
  logic                    sat_flag;

  modport master (
    output in_valid, shift_in, kernel_in, shamt, relu_en, out_ready,
    input  in_ready, out_valid, pixel_out, sat_flag
  );

  modport slave (
    input  in_valid, shift_in, kernel_in, shamt, relu_en, out_ready,
    output in_ready, out_valid, pixel_out, sat_flag
  );
endinterface

// File: rtl/conv_mac_seq.sv
// Sequential KxK convolution MAC: LANES signed multipliers time-shared over the taps,
// followed by a rounding right-shift, optional ReLU and saturation to BITS.
module conv_mac_seq #(
  parameter int unsigned BITS        = 9,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned LANES       = 3,
  parameter int unsigned SHIFT_BITS  = 4
) (
  input logic           clk,
  input logic           rst_n,
  conv_mac_seq_if.slave bus
);
  localparam int unsigned NTAPS     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned NPASS     = (NTAPS + LANES - 1) / LANES;
  localparam int unsigned NPAD      = NPASS * LANES;
  localparam int unsigned ACC_BITS  = 2 * BITS + $clog2(NTAPS) + 1;
  localparam int unsigned RES_BITS  = ACC_BITS + 1;
  localparam int unsigned PROD_BITS = 2 * BITS;
  localparam int unsigned PASS_W    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int unsigned OP_W      = NPAD * BITS;
  localparam int unsigned LANE_W    = LANES * BITS;

  localparam logic signed [RES_BITS-1:0] MAX_V = RES_BITS'(2 ** (BITS - 1) - 1);
  localparam logic signed [RES_BITS-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e                      state_q;
  logic [PASS_W-1:0]           pass_q;
  logic signed [ACC_BITS-1:0]  acc_q;
  logic [OP_W-1:0]             pix_q, ker_q;
  logic [OP_W-1:0]             pix_nxt_c, ker_nxt_c;
  logic [SHIFT_BITS-1:0]       shamt_q;
  logic                        relu_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [BITS-1:0]             pixel_q;
  logic                        sat_q;

  logic signed [PROD_BITS-1:0] prod_c;
  logic signed [ACC_BITS-1:0]  lane_sum_c;
  logic signed [ACC_BITS-1:0]  acc_fin_c;
  logic signed [RES_BITS-1:0]  rounded_c;
  logic signed [RES_BITS-1:0]  shifted_c;
  logic [BITS-1:0]             res_pix_c;
  logic                        res_sat_c;

  // Operands slide down by one pass each cycle, so the lanes always read the low taps;
  // padding taps beyond NTAPS are loaded as zero and contribute nothing.
  if (NPASS > 1) begin : g_shift
    assign pix_nxt_c = {LANE_W'(0), pix_q[OP_W-1:LANE_W]};
    assign ker_nxt_c = {LANE_W'(0), ker_q[OP_W-1:LANE_W]};
  end else begin : g_noshift
    assign pix_nxt_c = pix_q;
    assign ker_nxt_c = ker_q;
  end

  // Sum of this pass's lane products.
  always_comb begin
    prod_c     = '0;
    lane_sum_c = '0;
    for (int l = 0; l < LANES; l++) begin
      prod_c     = PROD_BITS'($signed(pix_q[l*BITS +: BITS])) *
                   PROD_BITS'($signed(ker_q[l*BITS +: BITS]));
      lane_sum_c = lane_sum_c + ACC_BITS'(prod_c);
    end
  end

  assign acc_fin_c = acc_q + lane_sum_c;

  // Round-half-up shift, ReLU, then clamp to the signed BITS range.
  always_comb begin
    rounded_c = RES_BITS'(acc_fin_c);
    if (shamt_q != '0) begin
      rounded_c = rounded_c + (RES_BITS'(1) << (shamt_q - SHIFT_BITS'(1)));
    end
    shifted_c = rounded_c >>> shamt_q;
    if (relu_q && shifted_c[RES_BITS-1]) begin
      shifted_c = '0;
    end
    res_pix_c = shifted_c[BITS-1:0];
    res_sat_c = 1'b0;
    if (shifted_c > MAX_V) begin
      res_pix_c = MAX_V[BITS-1:0];
      res_sat_c = 1'b1;
    end else if (shifted_c < MIN_V) begin
      res_pix_c = MIN_V[BITS-1:0];
      res_sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      acc_q       <= '0;
      pix_q       <= '0;
      ker_q       <= '0;
      shamt_q     <= '0;
      relu_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      pixel_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            pix_q      <= OP_W'(bus.shift_in);
            ker_q      <= OP_W'(bus.kernel_in);
            shamt_q    <= bus.shamt;
            relu_q     <= bus.relu_en;
            acc_q      <= '0;
            pass_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          pix_q <= pix_nxt_c;
          ker_q <= ker_nxt_c;
          acc_q <= acc_fin_c;
          if (pass_q == PASS_W'(NPASS - 1)) begin
            pixel_q     <= res_pix_c;
            sat_q       <= res_sat_c;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            pass_q <= pass_q + PASS_W'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pixel_out = pixel_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Randomised scoreboard bench for conv_mac_seq: a driver pushes expected results from an
// arithmetic model, a monitor pops and compares on every output handshake.
module tb_conv_mac_seq;
  localparam int unsigned BITS        = 9;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned SHIFT_BITS  = 4;
  parameter  int unsigned LANES       = 3;
  localparam int          NTAPS       = KERNEL_SIZE * KERNEL_SIZE;
  localparam int          NPASS       = (NTAPS + LANES - 1) / LANES;
  localparam int          N_RAND      = 40;

  typedef struct {
    logic signed [BITS-1:0] pix;
    logic                   sat;
    int                     acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  conv_mac_seq_if #(.BITS(BITS), .KERNEL_SIZE(KERNEL_SIZE), .SHIFT_BITS(SHIFT_BITS)) bus ();

  conv_mac_seq #(
    .BITS(BITS), .KERNEL_SIZE(KERNEL_SIZE), .LANES(LANES), .SHIFT_BITS(SHIFT_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t                   q[$];
  int                     n_tests = 0;
  int                     n_fail  = 0;
  int                     cyc     = 0;
  int                     cur_p[NTAPS];
  int                     cur_k[NTAPS];
  bit                     ready_rand = 1'b0;
  bit                     prev_ov    = 1'b0;
  logic signed [BITS-1:0] last_pix   = '0;
  logic                   last_sat   = 1'b0;
  int                     hs_edge    = 0;
  int                     last_acc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact dot product, round-half-up shift, ReLU, clamp.
  function automatic exp_t model(input int sh, input bit relu);
    exp_t   e;
    longint acc, r, mx, mn;
    acc = 0;
    for (int i = 0; i < NTAPS; i++) acc += longint'(cur_p[i]) * longint'(cur_k[i]);
    if (sh > 0) acc += longint'(1) << (sh - 1);
    r = acc >>> sh;
    if (relu && r < 0) r = 0;
    mx = (longint'(1) << (BITS - 1)) - 1;
    mn = -mx - 1;
    e.sat = 1'b0;
    if (r > mx) begin
      r = mx; e.sat = 1'b1;
    end else if (r < mn) begin
      r = mn; e.sat = 1'b1;
    end
    e.pix     = BITS'(r);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic fill(input int pv, input int kv);
    for (int i = 0; i < NTAPS; i++) begin
      cur_p[i] = pv;
      cur_k[i] = kv;
    end
  endtask

  function automatic int rand_tap();
    int v;
    case ($urandom_range(0, 5))
      0:       v = -256;
      1:       v = 255;
      default: v = int'($urandom_range(0, 511)) - 256;
    endcase
    return v;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < NTAPS; i++) begin
      cur_p[i] = rand_tap();
      cur_k[i] = rand_tap();
    end
  endtask

  task automatic drive_ops();
    logic [NTAPS*BITS-1:0] pv, kv;
    for (int i = 0; i < NTAPS; i++) begin
      pv[i*BITS +: BITS] = BITS'(cur_p[i]);
      kv[i*BITS +: BITS] = BITS'(cur_k[i]);
    end
    bus.shift_in  = pv;
    bus.kernel_in = kv;
  endtask

  // Present the current operands, wait for acceptance, queue the model result,
  // then scramble the operand inputs to show only the captured copy matters.
  task automatic send(input int sh, input bit relu);
    exp_t e;
    int   n;
    @(negedge clk);
    drive_ops();
    bus.shamt    = SHIFT_BITS'(sh);
    bus.relu_en  = relu;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", longint'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(sh, relu);
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    last_acc  = cyc;
    q.push_back(e);
    bus.in_valid = 1'b0;
    fill_rand();
    drive_ops();
    bus.shamt   = SHIFT_BITS'($urandom_range(0, 15));
    bus.relu_en = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: compare outputs against the queue head while valid, and the held value otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", longint'(bus.out_valid), 0);
          end else begin
            e = q[0];
            if (!prev_ov) check("latency", cyc - e.acc_cyc, NPASS);
            check("pixel_out", bus.pixel_out, e.pix);
            check("sat_flag", longint'(bus.sat_flag), longint'(e.sat));
            check("in_ready_in_hold", longint'(bus.in_ready), 0);
            if (bus.out_ready) begin
              void'(q.pop_front());
              last_pix = e.pix;
              last_sat = e.sat;
              hs_edge  = cyc + 1;
            end
          end
        end else begin
          check("held_pixel", bus.pixel_out, last_pix);
          check("held_sat", longint'(bus.sat_flag), longint'(last_sat));
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  // Random consumer backpressure, applied away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ready_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.shift_in  = '0;
    bus.kernel_in = '0;
    bus.shamt     = '0;
    bus.relu_en   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_pixel_out", bus.pixel_out, 0);
    check("rst_sat_flag", longint'(bus.sat_flag), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    rst_n = 1'b1;

    // Directed corner values.
    fill(0, 0);      send(0, 1'b0);
    fill(1, 1);      send(0, 1'b0); send(1, 1'b0); send(2, 1'b0);
    fill(255, 255);  send(0, 1'b0); send(8, 1'b0);
    fill(-256, 255); send(0, 1'b0); send(0, 1'b1);
    drain();

    // Backpressure: hold the result 5 cycles while a second bundle waits on in_valid.
    bus.out_ready = 1'b0;
    fill(1, 1);
    send(0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", longint'(bus.out_valid), 1);
    repeat (5) @(negedge clk);
    fork
      begin
        fill_rand();
        send(3, 1'b0);
      end
      begin
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
      end
    join
    check("bp_accept_after_handshake", last_acc - hs_edge, 1);
    drain();

    // Reset while accumulating aborts the bundle.
    fill_rand();
    send(2, 1'b0);
    rst_n = 1'b0;
    #2;
    check("abort_out_valid", longint'(bus.out_valid), 0);
    check("abort_pixel_out", bus.pixel_out, 0);
    check("abort_sat_flag", longint'(bus.sat_flag), 0);
    check("abort_in_ready", longint'(bus.in_ready), 1);
    q.delete();
    last_pix = '0;
    last_sat = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    send(1, 1'b1);
    drain();

    // Random bundles under random backpressure.
    ready_rand = 1'b1;
    for (int t = 0; t < N_RAND; t++) begin
      fill_rand();
      send(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    ready_rand = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
